uart_rx_serial: RTL and testbench

- Synthesizable UART receiver that turns the serial `rxd` line into bytes.
- It drives the same byte-level receive interface the CPU core already consumes: an `rx_ready` one-cycle strobe and `rx_data` byte, 8N1, LSB first.
- It is the wire-facing end of the receive path. The simulation-model serial receive is replaced by this block in FPGA builds.
- It adds 3-sample majority voting, false-start rejection and framing-error reporting.

---
 rtl/uart_rx_serial.sv | 155 +++++++++++++++
 tb/tb_uart_rx_serial.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_serial.sv
// ---------------------------------------------------------------------------
// uart_rx_serial
//   Wire-facing 8N1 UART receiver (LSB first). Synchronizes the raw serial
//   line, detects start edges, takes a 3-sample majority vote around the
//   middle of every bit and delivers whole bytes on a one-cycle strobe.
//   Bad start bits are rejected silently; a low stop bit is reported as a
//   framing error and the byte is dropped.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rxd        in   asynchronous serial line, idle high
//   rx_ready   out  one-cycle strobe, rx_data holds a new byte
//   rx_data    out  last correctly framed byte, held until the next one
//   frame_err  out  one-cycle strobe, stop bit sampled low, byte discarded
//   busy       out  receiver is inside a frame (state other than IDLE)
// ---------------------------------------------------------------------------
module uart_rx_serial #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(HALF);
  localparam logic [CW-1:0] SAMP_C   = CW'(HALF + 1);
  // Stop bit is decided one cycle after its last sample so the receiver is
  // back in IDLE about half a bit before a back-to-back start edge.
  localparam logic [CW-1:0] STOP_DEC = CW'(HALF + 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;      // sync_q[1] is the synchronized line "s"
  logic          prev_q;      // s delayed by one cycle, for edge detection
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitn_q;
  logic [7:0]    shift_q;
  logic [2:0]    samp_q;
  logic          rx_ready_q;
  logic          frame_err_q;
  logic [7:0]    rx_data_q;

  logic s;
  logic maj;

  assign s   = sync_q[1];
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
               (samp_q[1] & samp_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      prev_q      <= s;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Three samples straddling the bit centre feed the majority vote.
      if (state_q != IDLE) begin
        if (cnt_q == SAMP_A) samp_q[0] <= s;
        if (cnt_q == SAMP_B) samp_q[1] <= s;
        if (cnt_q == SAMP_C) samp_q[2] <= s;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Only a genuine 1->0 transition starts a frame; a line that
          // stays low (break) cannot retrigger.
          if (prev_q && !s) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            bitn_q <= '0;
            state_q <= maj ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            // Shift in from the top: after eight bits the first one
            // received sits in bit 0.
            shift_q <= {maj, shift_q[7:1]};
            if (bitn_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bitn_q <= bitn_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == STOP_DEC) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (maj) begin
              rx_data_q  <= shift_q;
              rx_ready_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign frame_err = frame_err_q;
  assign rx_data   = rx_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_serial.sv
module tb_uart_rx_serial;

  localparam int CPB     = 8;
  // Cycles from driving the start bit (at a falling clock edge) to seeing the
  // strobe at a falling clock edge; nominally 82 with this drive phase.
  localparam int LAT_MIN = 80;
  localparam int LAT_MAX = 84;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  uart_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cycles   = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cycles <= cycles + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycles);
    end
  endtask

  // Monitor: pops one expectation per strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_ready && frame_err) begin
        n_checks++;
        n_errors++;
        $display("FAIL both_strobes: rx_ready and frame_err high together at cycle %0d", cycles);
      end
      if (rx_ready || frame_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: rx_ready=%0b frame_err=%0b rx_data=%0h, none expected", rx_ready, frame_err, rx_data);
        end else begin
          exp_t e;
          int   lat;
          e   = exp_q.pop_front();
          lat = cycles - e.start_cyc;
          chk("strobe_is_frame_err", {31'd0, frame_err}, {31'd0, e.err});
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          n_checks++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_errors++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
          $display("strobe: err=%0b rx_data=%02h latency=%0d", frame_err, rx_data, lat);
        end
      end
    end
  end

  // Drives one 10-bit frame; glitch_win selects the bit window (0 = start,
  // 1..8 = data bits, -1 = none) that gets a one-clock inversion mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_win);
    exp_t       e;
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (stop) last_good = d;
    e.err       = ~stop;
    e.data      = last_good;
    e.start_cyc = cycles;
    exp_q.push_back(e);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rxd = (b == glitch_win && c == 5) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single frame
    send_frame(8'h55, 1'b1, -1);
    idle(20);

    // Back-to-back frames, no idle gap
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(20);

    // False start: 3-clock low pulse
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    chk("false_start_busy_high", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("false_start_busy_low", {31'd0, busy}, 32'd0);
    $display("false start: busy=%0b", busy);
    idle(10);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);

    // Framing error keeps previous data, next frame good
    send_frame(8'h81, 1'b0, -1);
    idle(20);
    chk("rx_data_held_after_ferr", {24'd0, rx_data}, 32'h3C);
    send_frame(8'h42, 1'b1, -1);
    idle(20);

    // Glitch on data bit 3 (window 4) of 0x0F
    send_frame(8'h0F, 1'b1, 4);
    idle(20);

    // Reset during bit 4 of a frame
    rxd = 1'b0;                               // start bit
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 4; b++) begin         // data bits 0..3 of 0x99
      rxd = (b == 0 || b == 3) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;                               // bit 4 of 0x99
    repeat (3) @(negedge clk);
    chk("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("abort_frame_err", {31'd0, frame_err}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
    $display("reset abort: busy=%0b rx_data=%02h", busy, rx_data);
    last_good = 8'h00;
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b1, -1);
    idle(30);

    chk("all_expected_strobes_seen", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
